// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// default cache geometry and word width.
// Optional feature macro: ICACHE_EN (enables the instruction cache).
package inst_fetch_pkg;

    localparam int unsigned IDX_W_DEF = 6;
    localparam int unsigned WORD_W    = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MISS = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_icache_array.sv
// Direct-mapped instruction cache storage, one 32-bit word per line.
// Combinational read by index, synchronous write, async clear of valid bits.
// Only instantiated when ICACHE_EN is defined.
module icache_array
    import inst_fetch_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEF,
    parameter int unsigned TAG_W = 30 - IDX_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [WORD_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [WORD_W-1:0] wr_data
);

    localparam int unsigned LINES = 1 << IDX_W;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [WORD_W-1:0] data_mem [LINES];

    // Valid bits: cleared by reset, set on every line fill
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage: plain memories, no reset needed
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: serves decoder fetch requests from a direct-mapped
// cache or from the memory controller, and absorbs pipeline flushes without
// abandoning an in-flight memory read.
// Optional feature macro: ICACHE_EN (cache array and hit path).
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        if_enable,
    input  logic [31:0] if_addr,
    output logic        inst_ready,
    output logic [31:0] inst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data
);

    fetch_state_e state_q, state_d;
    logic         inst_ready_q, inst_ready_d;
    logic [31:0]  inst_q, inst_d;
    logic         mem_req_q, mem_req_d;
    logic [31:0]  mem_addr_q, mem_addr_d;
    logic         fill_en;
    logic         hit;
    logic [WORD_W-1:0] hit_data;

    // Bits [1:0] of the fetch address never matter for word fetches
    logic unused_addr_lo;
    assign unused_addr_lo = ^if_addr[1:0];

`ifdef ICACHE_EN
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;

    icache_array #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_icache_array (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rd_idx   (if_addr[IDX_W+1:2]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (hit_data),
        .wr_en    (fill_en && rdy_in),
        .wr_idx   (mem_addr_q[IDX_W+1:2]),
        .wr_tag   (mem_addr_q[31:IDX_W+2]),
        .wr_data  (mem_data)
    );

    assign hit = rd_valid && (rd_tag == if_addr[31:IDX_W+2]);
`else
    logic             unused_fill;
    logic [IDX_W-1:0] unused_idx;
    assign unused_fill = fill_en;
    assign unused_idx  = if_addr[IDX_W+1:2];
    assign hit         = 1'b0;
    assign hit_data    = '0;
`endif

    // Next-state and output-register logic for the fetch FSM
    always_comb begin
        state_d      = state_q;
        inst_ready_d = 1'b0;
        inst_d       = inst_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        fill_en      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (if_enable && !clear) begin
                    if (hit) begin
                        inst_d       = hit_data;
                        inst_ready_d = 1'b1;
                    end else begin
                        mem_addr_d = {if_addr[31:2], 2'b00};
                        mem_req_d  = 1'b1;
                        state_d    = S_MISS;
                    end
                end
            end
            S_MISS: begin
                // A returning word is always written back, even when flushed
                if (mem_ready) begin
                    fill_en   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                    if (!clear) begin
                        inst_d       = mem_data;
                        inst_ready_d = 1'b1;
                    end
                end else if (clear) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (mem_ready) begin
                    fill_en   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and output registers; everything frozen while rdy_in is low
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= S_IDLE;
            inst_ready_q <= 1'b0;
            inst_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            inst_ready_q <= inst_ready_d;
            inst_q       <= inst_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    assign inst_ready = inst_ready_q;
    assign inst       = inst_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed fetches push the expected word,
// a monitor pops and compares on every inst_ready pulse.
// Expectations for cached refetches depend on ICACHE_EN.
module tb_inst_fetch;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        if_enable;
    logic [31:0] if_addr;
    logic        inst_ready;
    logic [31:0] inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;

    always #5 clk_in = ~clk_in;

    inst_fetch #(.IDX_W(6)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clear      (clear),
        .if_enable  (if_enable),
        .if_addr    (if_addr),
        .inst_ready (inst_ready),
        .inst       (inst),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_data   (mem_data)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pushed = 0;
    int          n_pulses = 0;
    logic        prev_ready = 1'b0;
    logic [31:0] exp_q [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_0100: return 32'h0010_0093;
            32'h0000_0040: return 32'h0000_0513;
            default:       return a ^ 32'hA5A5_0F0F;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    // Monitor: every inst_ready pulse must match the oldest expected word
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (inst_ready) begin
                n_pulses++;
                check("no_back_to_back", {31'b0, prev_ready}, 32'h0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", inst, 32'hFFFF_FFFF ^ inst);
                end else begin
                    check("inst_data", inst, exp_q.pop_front());
                end
            end
            prev_ready = inst_ready;
        end else begin
            prev_ready = 1'b0;
        end
    end

    task automatic fetch_miss(input logic [31:0] addr, input int delay);
        if_enable = 1'b1;
        if_addr   = addr;
        exp_q.push_back(mem_word(addr));
        n_pushed++;
        tick();
        if_enable = 1'b0;
        check("miss_req", {31'b0, mem_req}, 32'h1);
        check("miss_addr", mem_addr, addr);
        check("miss_no_ready", {31'b0, inst_ready}, 32'h0);
        repeat (delay - 1) begin
            tick();
            check("miss_req_hold", {31'b0, mem_req}, 32'h1);
        end
        mem_ready = 1'b1;
        mem_data  = mem_word(addr);
        tick();
        mem_ready = 1'b0;
        mem_data  = '0;
        check("fill_pulse", {31'b0, inst_ready}, 32'h1);
        check("fill_req_drop", {31'b0, mem_req}, 32'h0);
        tick();
        check("fill_pulse_single", {31'b0, inst_ready}, 32'h0);
    endtask

    task automatic fetch_hit(input logic [31:0] addr);
        if_enable = 1'b1;
        if_addr   = addr;
        exp_q.push_back(mem_word(addr));
        n_pushed++;
        tick();
        if_enable = 1'b0;
        check("hit_pulse", {31'b0, inst_ready}, 32'h1);
        check("hit_no_req", {31'b0, mem_req}, 32'h0);
        tick();
    endtask

    task automatic fetch_cached(input logic [31:0] addr);
`ifdef ICACHE_EN
        fetch_hit(addr);
`else
        fetch_miss(addr, 2);
`endif
    endtask

    initial begin
        rst_in    = 1'b1;
        rdy_in    = 1'b1;
        clear     = 1'b0;
        if_enable = 1'b0;
        if_addr   = '0;
        mem_ready = 1'b0;
        mem_data  = '0;
        repeat (2) tick();
        check("rst_inst_ready", {31'b0, inst_ready}, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        rst_in = 1'b0;
        tick();

        // Idle with no request
        tick();
        check("idle_no_ready", {31'b0, inst_ready}, 32'h0);
        check("idle_no_req", {31'b0, mem_req}, 32'h0);

        // Cold miss, then refetch of the same word
        fetch_miss(32'h0000_0000, 3);
        fetch_cached(32'h0000_0000);

        // Conflicting lines on index 0
        fetch_miss(32'h0000_0100, 2);
        fetch_miss(32'h0000_0000, 2);

        // Clear while idle suppresses the request
        if_enable = 1'b1;
        if_addr   = 32'h0000_0500;
        clear     = 1'b1;
        tick();
        if_enable = 1'b0;
        clear     = 1'b0;
        check("clr_idle_no_ready", {31'b0, inst_ready}, 32'h0);
        check("clr_idle_no_req", {31'b0, mem_req}, 32'h0);
        tick();

        // Clear mid-miss: request held until memory answers, word still filled
        if_enable = 1'b1;
        if_addr   = 32'h0000_0040;
        tick();
        if_enable = 1'b0;
        check("drop_req", {31'b0, mem_req}, 32'h1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("drop_req_hold", {31'b0, mem_req}, 32'h1);
        tick();
        check("drop_req_hold2", {31'b0, mem_req}, 32'h1);
        check("drop_addr", mem_addr, 32'h0000_0040);
        mem_ready = 1'b1;
        mem_data  = mem_word(32'h0000_0040);
        tick();
        mem_ready = 1'b0;
        check("drop_req_done", {31'b0, mem_req}, 32'h0);
        check("drop_no_ready", {31'b0, inst_ready}, 32'h0);
        tick();
        fetch_cached(32'h0000_0040);

        // Clear in the same cycle as mem_ready
        if_enable = 1'b1;
        if_addr   = 32'h0000_0080;
        tick();
        if_enable = 1'b0;
        mem_ready = 1'b1;
        mem_data  = mem_word(32'h0000_0080);
        clear     = 1'b1;
        tick();
        mem_ready = 1'b0;
        clear     = 1'b0;
        check("clr_ack_no_ready", {31'b0, inst_ready}, 32'h0);
        check("clr_ack_req_drop", {31'b0, mem_req}, 32'h0);
        tick();
        fetch_cached(32'h0000_0080);

        // rdy_in low during a miss freezes everything
        if_enable = 1'b1;
        if_addr   = 32'h0000_0204;
        exp_q.push_back(mem_word(32'h0000_0204));
        n_pushed++;
        tick();
        if_enable = 1'b0;
        check("stall_req", {31'b0, mem_req}, 32'h1);
        rdy_in = 1'b0;
        repeat (5) begin
            tick();
            check("stall_req_hold", {31'b0, mem_req}, 32'h1);
            check("stall_addr_hold", mem_addr, 32'h0000_0204);
            check("stall_no_ready", {31'b0, inst_ready}, 32'h0);
        end
        rdy_in = 1'b1;
        tick();
        check("stall_resume_req", {31'b0, mem_req}, 32'h1);
        mem_ready = 1'b1;
        mem_data  = mem_word(32'h0000_0204);
        tick();
        mem_ready = 1'b0;
        mem_data  = '0;
        check("stall_fill_pulse", {31'b0, inst_ready}, 32'h1);
        check("stall_fill_req_drop", {31'b0, mem_req}, 32'h0);
        tick();

        // Asynchronous reset in the middle of a miss
        if_enable = 1'b1;
        if_addr   = 32'h0000_0300;
        tick();
        if_enable = 1'b0;
        check("rstmiss_req", {31'b0, mem_req}, 32'h1);
        #2;
        rst_in = 1'b1;
        #1;
        check("rstmiss_req_drop", {31'b0, mem_req}, 32'h0);
        check("rstmiss_addr", mem_addr, 32'h0);
        tick();
        rst_in = 1'b0;
        tick();

        // Valid bits cleared: previously cached word misses again
        fetch_miss(32'h0000_0000, 3);
        fetch_cached(32'h0000_0000);

        repeat (2) tick();
        check("queue_drained", exp_q.size(), 32'h0);
        check("pulse_count", n_pulses, n_pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
